// File: rtl/synth_pkg.sv
// Shared synth definitions: voice state encoding and default sizing.
// Used by voice_allocator and voice_slot.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    localparam int N_KEYS_DEF     = 36;
    localparam int NUM_VOICES_DEF = 4;
    localparam int KEY_W_DEF      = $clog2(N_KEYS_DEF);
    localparam int CNT_W          = 24;
    localparam int AGE_W_DEF      = 16;

    localparam logic [CNT_W-1:0] RELEASE_CYCLES_DEF = 24'd3000000;

endpackage

// File: rtl/voice_slot.sv
// One shared voice: IDLE/ACTIVE/RELEASE FSM, release tail counter,
// age counter and the key index it owns.
module voice_slot
    import synth_pkg::*;
#(
    parameter int               KEY_W          = KEY_W_DEF,
    parameter int               AGE_W          = AGE_W_DEF,
    parameter logic [CNT_W-1:0] RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grant,
    input  logic [KEY_W-1:0] grant_key,
    input  logic             rel,
    output voice_state_t     state,
    output logic [KEY_W-1:0] key,
    output logic [AGE_W-1:0] age
);

    voice_state_t     state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [KEY_W-1:0] key_n;
    logic [AGE_W-1:0] age_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            key   <= '0;
            age   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key   <= key_n;
            age   <= age_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        key_n   = key;
        age_n   = age;
        if (state != IDLE && age != '1) begin
            age_n = age + 1'b1;
        end
        // A grant (new key, retrigger or steal) overrides any tail in progress.
        if (grant) begin
            state_n = ACTIVE;
            key_n   = grant_key;
            cnt_n   = '0;
            age_n   = '0;
        end else begin
            unique case (state)
                ACTIVE: begin
                    if (rel) begin
                        if (RELEASE_CYCLES == '0) begin
                            state_n = IDLE;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = RELEASE_CYCLES - 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Key-edge detection, press queue and lowest-key-first voice grants.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice instead of dropping.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int               N_KEYS         = N_KEYS_DEF,
    parameter int               NUM_VOICES     = NUM_VOICES_DEF,
    parameter int               KEY_W          = KEY_W_DEF,
    parameter logic [CNT_W-1:0] RELEASE_CYCLES = RELEASE_CYCLES_DEF,
    parameter int               AGE_W          = AGE_W_DEF
) (
    input  logic                        clk50,
    input  logic                        reset,
    input  logic [N_KEYS-1:0]           key_in,
    output logic [NUM_VOICES-1:0]       voice_on,
    output logic [NUM_VOICES-1:0]       voice_rel,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic                        drop
);

    logic [N_KEYS-1:0]     key_q, pend, pend_n;
    logic [N_KEYS-1:0]     press_edge, rel_edge;
    logic [KEY_W-1:0]      sel;
    logic                  sel_any, sel_rel, do_grant, found, drop_n;
    logic [NUM_VOICES-1:0] tgt, grant_vec, rel_hit;

    voice_state_t     states [NUM_VOICES];
    logic [KEY_W-1:0] keys   [NUM_VOICES];
    logic [AGE_W-1:0] ages   [NUM_VOICES];

`ifdef VOICE_ALLOC_STEAL_EN
    logic             have_rel, steal_ok;
    logic [AGE_W-1:0] best;
`else
    logic [AGE_W-1:0] unused_age;
    always_comb begin
        unused_age = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            unused_age = unused_age ^ ages[v];
        end
    end
`endif

    assign press_edge = key_in & ~key_q;
    assign rel_edge   = ~key_in & key_q;

    always_ff @(posedge clk50) begin
        if (reset) begin
            key_q <= '0;
            pend  <= '0;
            drop  <= 1'b0;
        end else begin
            key_q <= key_in;
            pend  <= pend_n;
            drop  <= drop_n;
        end
    end

    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        sel_rel = 1'b0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel     = KEY_W'(i);
                sel_any = 1'b1;
                sel_rel = rel_edge[i];
            end
        end
    end

    always_comb begin
        tgt   = '0;
        found = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!found && states[v] == RELEASE && keys[v] == sel) begin
                tgt[v] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!found && states[v] == IDLE) begin
                tgt[v] = 1'b1;
                found  = 1'b1;
            end
        end
`ifdef VOICE_ALLOC_STEAL_EN
        have_rel = 1'b0;
        steal_ok = 1'b0;
        best     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (states[v] == RELEASE) have_rel = 1'b1;
        end
        // Oldest voice of the preferred class; strict > keeps ties low.
        if (!found) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if ((have_rel ? states[v] == RELEASE : states[v] == ACTIVE)
                    && (!steal_ok || ages[v] > best)) begin
                    tgt      = '0;
                    tgt[v]   = 1'b1;
                    best     = ages[v];
                    steal_ok = 1'b1;
                end
            end
            found = steal_ok;
        end
`endif
    end

    // A release of the selected key cancels both grant and drop.
    assign do_grant  = sel_any && !sel_rel;
    assign grant_vec = do_grant ? tgt : '0;
    assign drop_n    = do_grant && !found;

    always_comb begin
        pend_n = pend;
        for (int i = 0; i < N_KEYS; i++) begin
            if (do_grant && sel == KEY_W'(i)) pend_n[i] = 1'b0;
        end
        pend_n = (pend_n | press_edge) & ~rel_edge;
    end

    always_comb begin
        rel_hit = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (keys[v] == KEY_W'(k) && rel_edge[k]) rel_hit[v] = 1'b1;
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
        voice_slot #(
            .KEY_W          (KEY_W),
            .AGE_W          (AGE_W),
            .RELEASE_CYCLES (RELEASE_CYCLES)
        ) u_slot (
            .clk       (clk50),
            .reset     (reset),
            .grant     (grant_vec[v]),
            .grant_key (sel),
            .rel       (rel_hit[v]),
            .state     (states[v]),
            .key       (keys[v]),
            .age       (ages[v])
        );
        assign voice_on[v]                 = states[v] != IDLE;
        assign voice_rel[v]                = states[v] == RELEASE;
        assign voice_key[v*KEY_W +: KEY_W] = keys[v];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator with a 5-cycle release tail.
module tb_voice_allocator;

    localparam int NK = 36;
    localparam int NV = 4;
    localparam int KW = 6;

    logic          clk50 = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic [NV-1:0] voice_on, voice_rel;
    logic [NV*KW-1:0] voice_key;
    logic          drop;

    int n_asserts = 0;
    int failures  = 0;

    typedef struct {
        string          tag;
        logic [NV-1:0]  on;
        logic [NV-1:0]  rel;
        logic [NV*KW-1:0] key;
        logic           drp;
    } exp_t;

    exp_t sb[$];

    voice_allocator #(
        .N_KEYS         (NK),
        .NUM_VOICES     (NV),
        .KEY_W          (KW),
        .RELEASE_CYCLES (24'd5),
        .AGE_W          (16)
    ) dut (
        .clk50     (clk50),
        .reset     (reset),
        .key_in    (key_in),
        .voice_on  (voice_on),
        .voice_rel (voice_rel),
        .voice_key (voice_key),
        .drop      (drop)
    );

    always #10 clk50 = ~clk50;

    function automatic logic [NV*KW-1:0] pk(int k3, int k2, int k1, int k0);
        return {KW'(k3), KW'(k2), KW'(k1), KW'(k0)};
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic push_exp(string tag, logic [NV-1:0] on, logic [NV-1:0] rel,
                            logic [NV*KW-1:0] key, logic drp);
        exp_t e;
        e.tag = tag;
        e.on  = on;
        e.rel = rel;
        e.key = key;
        e.drp = drp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_asserts++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_asserts++;
            assert (voice_on === e.on) else begin
                failures++;
                $error("FAIL %s.voice_on observed=%b expected=%b", e.tag, voice_on, e.on);
            end
            n_asserts++;
            assert (voice_rel === e.rel) else begin
                failures++;
                $error("FAIL %s.voice_rel observed=%b expected=%b", e.tag, voice_rel, e.rel);
            end
            n_asserts++;
            assert (voice_key === e.key) else begin
                failures++;
                $error("FAIL %s.voice_key observed=%h expected=%h", e.tag, voice_key, e.key);
            end
            n_asserts++;
            assert (drop === e.drp) else begin
                failures++;
                $error("FAIL %s.drop observed=%b expected=%b", e.tag, drop, e.drp);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        key_in = '0;
        push_exp("reset", 4'h0, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(2);
        check_out();
        reset = 1'b0;
        step(1);

        // single uncontended press and release tail
        key_in[0] = 1'b1;
        push_exp("t1_pend", 4'h0, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();
        push_exp("t1_on", 4'h1, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();
        step(3);
        key_in[0] = 1'b0;
        push_exp("t1_rel", 4'h1, 4'h1, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();
        push_exp("t1_tail", 4'h1, 4'h1, pk(0, 0, 0, 0), 1'b0);
        step(4); check_out();
        push_exp("t1_off", 4'h0, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();

        // simultaneous presses granted lowest key first
        key_in[1] = 1'b1;
        key_in[3] = 1'b1;
        key_in[7] = 1'b1;
        step(1);
        push_exp("t2_g1", 4'h1, 4'h0, pk(0, 0, 0, 1), 1'b0);
        step(1); check_out();
        push_exp("t2_g2", 4'h3, 4'h0, pk(0, 0, 3, 1), 1'b0);
        step(1); check_out();
        push_exp("t2_g3", 4'h7, 4'h0, pk(0, 7, 3, 1), 1'b0);
        step(1); check_out();

        // retrigger during the release tail reuses the same voice
        key_in[3] = 1'b0;
        push_exp("t3_rel", 4'h7, 4'h2, pk(0, 7, 3, 1), 1'b0);
        step(1); check_out();
        key_in[3] = 1'b1;
        step(1);
        push_exp("t3_retrig", 4'h7, 4'h0, pk(0, 7, 3, 1), 1'b0);
        step(1); check_out();

        // overflow: five presses onto four voices
        key_in = '0;
        push_exp("t4_idle", 4'h0, 4'h0, pk(0, 7, 3, 1), 1'b0);
        step(7); check_out();
        key_in[4:0] = 5'h1f;
        push_exp("t4_full", 4'hf, 4'h0, pk(3, 2, 1, 0), 1'b0);
        step(5); check_out();
`ifdef VOICE_ALLOC_STEAL_EN
        push_exp("t4_fifth", 4'hf, 4'h0, pk(3, 2, 1, 4), 1'b0);
        step(1); check_out();
        push_exp("t4_after", 4'hf, 4'h0, pk(3, 2, 1, 4), 1'b0);
        step(1); check_out();
`else
        push_exp("t4_fifth", 4'hf, 4'h0, pk(3, 2, 1, 0), 1'b1);
        step(1); check_out();
        push_exp("t4_after", 4'hf, 4'h0, pk(3, 2, 1, 0), 1'b0);
        step(1); check_out();
`endif

        // releasing voice preferred as steal victim; plain build drops
        key_in[2] = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
        push_exp("t5_rel", 4'hf, 4'h4, pk(3, 2, 1, 4), 1'b0);
        step(1); check_out();
        key_in[5] = 1'b1;
        step(1);
        push_exp("t5_new", 4'hf, 4'h0, pk(3, 5, 1, 4), 1'b0);
        step(1); check_out();
        key_in[0] = 1'b0;
        push_exp("t6_oldkey", 4'hf, 4'h0, pk(3, 5, 1, 4), 1'b0);
        step(1); check_out();
`else
        push_exp("t5_rel", 4'hf, 4'h4, pk(3, 2, 1, 0), 1'b0);
        step(1); check_out();
        key_in[5] = 1'b1;
        step(1);
        push_exp("t5_new", 4'hf, 4'h4, pk(3, 2, 1, 0), 1'b1);
        step(1); check_out();
        key_in[0] = 1'b0;
        push_exp("t6_oldkey", 4'hf, 4'h5, pk(3, 2, 1, 0), 1'b0);
        step(1); check_out();
`endif

        // reset mid-operation, then held keys are re-granted
        reset  = 1'b1;
        key_in = '0;
        push_exp("t7_rst", 4'h0, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();
        step(1);
        reset      = 1'b0;
        key_in[10] = 1'b1;
        key_in[11] = 1'b1;
        key_in[12] = 1'b1;
        push_exp("t7_three", 4'h7, 4'h0, pk(0, 12, 11, 10), 1'b0);
        step(4); check_out();
        key_in[20] = 1'b1;
        key_in[21] = 1'b1;
        step(1);
        reset = 1'b1;
        push_exp("t7_abort", 4'h0, 4'h0, pk(0, 0, 0, 0), 1'b0);
        step(1); check_out();
        reset = 1'b0;
        push_exp("t7_regrant", 4'hf, 4'h0, pk(20, 12, 11, 10), 1'b0);
        step(5); check_out();
`ifdef VOICE_ALLOC_STEAL_EN
        push_exp("t7_fifth", 4'hf, 4'h0, pk(20, 12, 11, 21), 1'b0);
`else
        push_exp("t7_fifth", 4'hf, 4'h0, pk(20, 12, 11, 10), 1'b1);
`endif
        step(1); check_out();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, failures);
        $finish;
    end

endmodule
